// File: rtl/imem_arbiter_pkg.sv
// Shared types for the instruction-side memory arbiter.
// RAM handshake states, word type and arbiter FSM states.
package imem_arbiter_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } imem_arb_state_t;

   // Width of a CPU index; at least one bit so a single-CPU build still has a port.
   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first asserted request at or after rr_ptr, wrapping mod CPUS.
// Purely combinational rotate-and-priority-encode.
module rr_picker
   import imem_arbiter_pkg::*;
#(
   parameter int unsigned CPUS = 2,
   localparam int unsigned IdW = id_width(CPUS)
) (
   input  logic [CPUS-1:0] req,
   input  logic [IdW-1:0]  rr_ptr,
   output logic            valid,
   output logic [IdW-1:0]  idx
);

   localparam logic [IdW:0] NCpu = (IdW+1)'(CPUS);

   logic [2*CPUS-1:0] dbl;
   logic [CPUS-1:0]   rot;
   logic [IdW-1:0]    off;
   logic [IdW:0]      sum;

   always_comb begin
      // rot[i] is the request of CPU (rr_ptr + i) mod CPUS
      dbl = {req, req} >> rr_ptr;
      rot = dbl[CPUS-1:0];
      off = '0;
      for (int i = CPUS - 1; i >= 0; i--) begin
         if (rot[i]) off = IdW'(i);
      end
      sum = {1'b0, rr_ptr} + {1'b0, off};
      if (sum >= NCpu) sum = sum - NCpu;
      valid = |rot;
      idx   = sum[IdW-1:0];
   end

endmodule

// File: rtl/imem_arbiter.sv
// Serialises per-CPU icache fill requests onto the single instruction RAM port,
// round-robin between CPUs, yielding to the data side whenever dbusy is high.
module imem_arbiter
   import imem_arbiter_pkg::*;
#(
   parameter int unsigned CPUS      = 2,
   parameter int unsigned TO_CYCLES = 64,
   localparam int unsigned IdW      = id_width(CPUS)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [CPUS-1:0]    iREN,
   input  logic [CPUS*32-1:0] iaddr,
   output logic [CPUS-1:0]    iwait,
   output logic [CPUS*32-1:0] iload,
   input  logic             dbusy,
   output logic             ramREN,
   output word_t            ramaddr,
   input  word_t            ramload,
   input  ramstate_t        ramstate,
   output logic [IdW-1:0]   grant_id,
   output logic             err_timeout
);

   localparam int unsigned  WdW  = $clog2(TO_CYCLES + 1);
   localparam logic [IdW:0] NCpu = (IdW+1)'(CPUS);

   imem_arb_state_t state_q, state_d;
   logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [IdW-1:0]  grant_q, grant_d;
   word_t           addr_q, addr_d;
   logic [WdW-1:0]  wd_q, wd_d;
   logic            err_q, err_d;

   logic            pick_valid;
   logic [IdW-1:0]  pick_idx;
   logic            req_held;
   logic            hit;
   logic [IdW:0]    nxt_ptr;

   rr_picker #(
      .CPUS(CPUS)
   ) u_picker (
      .req    (iREN),
      .rr_ptr (rr_ptr_q),
      .valid  (pick_valid),
      .idx    (pick_idx)
   );

   assign req_held = iREN[grant_q];
   assign hit      = (state_q == REQ) && !dbusy && req_held && (ramstate == ACCESS);

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      addr_d   = addr_q;
      wd_d     = wd_q;
      err_d    = err_q;
      nxt_ptr  = {1'b0, grant_q} + (IdW+1)'(1);
      if (nxt_ptr >= NCpu) nxt_ptr = '0;

      unique case (state_q)
         IDLE: begin
            if (!dbusy && pick_valid) begin
               state_d = REQ;
               grant_d = pick_idx;
               addr_d  = iaddr[32*pick_idx +: 32];
               wd_d    = '0;
            end
         end
         REQ: begin
            if (wd_q != WdW'(TO_CYCLES)) wd_d = wd_q + WdW'(1);
            if (!hit && (wd_q == WdW'(TO_CYCLES - 1))) err_d = 1'b1;
            // Data-side preemption and abandonment both leave rr_ptr alone
            if (dbusy || !req_held) begin
               state_d = IDLE;
            end else if (ramstate == ACCESS) begin
               state_d  = IDLE;
               rr_ptr_d = nxt_ptr[IdW-1:0];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         addr_q   <= '0;
         wd_q     <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         addr_q   <= addr_d;
         wd_q     <= wd_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      iwait = '1;
      iload = '0;
      if (hit) begin
         iwait[grant_q]            = 1'b0;
         iload[32*grant_q +: 32]   = ramload;
      end
   end

   assign ramREN      = (state_q == REQ) && !dbusy;
   assign ramaddr     = addr_q;
   assign grant_id    = grant_q;
   assign err_timeout = err_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter (CPUS=2): expected fills queued by the stimulus,
// popped and compared by a monitor whenever an iwait line drops.
module tb_imem_arbiter;
   import imem_arbiter_pkg::*;

   typedef struct {
      int          cpu;
      logic [31:0] data;
   } exp_t;

   logic        CLK;
   logic        RST;
   logic [1:0]  iREN;
   logic [63:0] iaddr;
   logic [1:0]  iwait;
   logic [63:0] iload;
   logic        dbusy;
   logic        ramREN;
   word_t       ramaddr;
   word_t       ramload;
   ramstate_t   ramstate;
   logic [0:0]  grant_id;
   logic        err_timeout;

   logic        model_on;
   word_t       ram_data;

   int checks;
   int errors;
   exp_t sb[$];
   exp_t mon_e;
   int   mon_cpu;

   // Simple RAM model: either a fixed word or an address-derived word
   assign ramload = model_on ? (ramaddr ^ 32'h1234_0000) : ram_data;

   imem_arbiter #(
      .CPUS      (2),
      .TO_CYCLES (64)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .iREN        (iREN),
      .iaddr       (iaddr),
      .iwait       (iwait),
      .iload       (iload),
      .dbusy       (dbusy),
      .ramREN      (ramREN),
      .ramaddr     (ramaddr),
      .ramload     (ramload),
      .ramstate    (ramstate),
      .grant_id    (grant_id),
      .err_timeout (err_timeout)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   task automatic do_reset();
      RST = 1'b1;
      cyc();
      cyc();
      RST = 1'b0;
   endtask

   // Monitor: every dropped iwait must match the next queued fill
   always @(negedge CLK) begin
      if (!RST && iwait !== 2'b11) begin
         checks++;
         if ($countones(~iwait) != 1 || sb.size() == 0) begin
            errors++;
            $display("FAIL completion: iwait=%b queued=%0d expected one low with a queued fill",
                     iwait, sb.size());
         end else begin
            mon_e   = sb.pop_front();
            mon_cpu = iwait[0] ? 1 : 0;
            if (mon_cpu != mon_e.cpu || iload[32*mon_cpu +: 32] !== mon_e.data ||
                iload[32*(1-mon_cpu) +: 32] !== 32'h0) begin
               errors++;
               $display("FAIL fill_data: got cpu %0d iload %h expected cpu %0d data %h",
                        mon_cpu, iload, mon_e.cpu, mon_e.data);
            end
         end
      end
   end

   initial begin
      checks   = 0;
      errors   = 0;
      RST      = 1'b1;
      iREN     = '0;
      iaddr    = '0;
      dbusy    = 1'b0;
      ramstate = FREE;
      model_on = 1'b0;
      ram_data = '0;
      cyc();
      cyc();
      chk("rst_ramREN", ramREN, 0);
      chk("rst_ramaddr", ramaddr, 0);
      chk("rst_iwait", iwait, 2'b11);
      chk("rst_iload", iload[31:0] | iload[63:32], 0);
      chk("rst_grant", grant_id, 0);
      chk("rst_err", err_timeout, 0);
      RST = 1'b0;
      cyc();

      // 1) single CPU0 fill, three BUSY cycles then ACCESS
      iREN         = 2'b01;
      iaddr[31:0]  = 32'h40;
      ramstate     = BUSY;
      ram_data     = 32'hDEAD_BEEF;
      sb.push_back('{cpu: 0, data: 32'hDEAD_BEEF});
      #1 chk("t1_idle_ren", ramREN, 0);
      cyc();
      #1 chk("t1_ren", ramREN, 1);
      chk("t1_addr", ramaddr, 32'h40);
      chk("t1_grant", grant_id, 0);
      chk("t1_iwait_busy", iwait, 2'b11);
      cyc();
      cyc();
      #1 chk("t1_iwait_busy3", iwait, 2'b11);
      cyc();
      ramstate = ACCESS;
      cyc();
      iREN     = 2'b00;
      ramstate = FREE;
      #1 chk("t1_idle_after", ramREN, 0);

      // 2) both CPUs requesting, RAM always ready: grants alternate from 0
      do_reset();
      model_on = 1'b1;
      iaddr    = {32'h200, 32'h100};
      iREN     = 2'b11;
      ramstate = ACCESS;
      sb.push_back('{cpu: 0, data: 32'h1234_0100});
      sb.push_back('{cpu: 1, data: 32'h1234_0200});
      sb.push_back('{cpu: 0, data: 32'h1234_0100});
      sb.push_back('{cpu: 1, data: 32'h1234_0200});
      for (int i = 0; i < 8; i++) begin
         cyc();
         if (i % 2 == 0) #1 chk("t2_grant", grant_id, (i / 2) % 2);
      end
      iREN     = 2'b00;
      ramstate = FREE;
      model_on = 1'b0;
      cyc();

      // 3) dbusy preempts CPU1's fill, which is re-granted and completes
      iREN          = 2'b10;
      iaddr[63:32]  = 32'h300;
      ramstate      = BUSY;
      ram_data      = 32'hCAFE_F00D;
      sb.push_back('{cpu: 1, data: 32'hCAFE_F00D});
      cyc();
      #1 chk("t3_grant", grant_id, 1);
      chk("t3_ren", ramREN, 1);
      cyc();
      dbusy = 1'b1;
      #1 chk("t3_ren_dbusy", ramREN, 0);
      cyc();
      #1 chk("t3_idle_dbusy", ramREN, 0);
      dbusy = 1'b0;
      cyc();
      #1 chk("t3_regrant", grant_id, 1);
      chk("t3_addr", ramaddr, 32'h300);
      chk("t3_ren2", ramREN, 1);
      ramstate = ACCESS;
      cyc();
      iREN     = 2'b00;
      ramstate = FREE;

      // 4a) ERROR is retried, single completion, no timeout
      iREN        = 2'b01;
      iaddr[31:0] = 32'h500;
      ramstate    = ERROR;
      ram_data    = 32'h0BAD_F00D;
      sb.push_back('{cpu: 0, data: 32'h0BAD_F00D});
      for (int i = 0; i < 5; i++) begin
         cyc();
         #1 chk("t4_err_ren", ramREN, 1);
         chk("t4_err_iwait", iwait, 2'b11);
      end
      cyc();
      ramstate = ACCESS;
      cyc();
      iREN     = 2'b00;
      ramstate = FREE;
      #1 chk("t4_no_timeout", err_timeout, 0);

      // 4b) 64 BUSY REQ cycles trip the sticky watchdog
      iREN        = 2'b01;
      iaddr[31:0] = 32'h600;
      ramstate    = BUSY;
      for (int i = 1; i <= 64; i++) begin
         cyc();
         if (i == 64) begin
            #1 chk("t4_wd_before", err_timeout, 0);
            chk("t4_wd_ren", ramREN, 1);
         end
      end
      cyc();
      #1 chk("t4_wd_set", err_timeout, 1);
      ramstate = ACCESS;
      ram_data = 32'h1234_5678;
      sb.push_back('{cpu: 0, data: 32'h1234_5678});
      cyc();
      iREN     = 2'b00;
      ramstate = FREE;
      #1 chk("t4_wd_sticky", err_timeout, 1);

      // 5a) CPU0 abandons mid-REQ; drop outranks a coincident ACCESS
      iREN        = 2'b01;
      iaddr[31:0] = 32'h700;
      ramstate    = BUSY;
      cyc();
      #1 chk("t5_ren", ramREN, 1);
      cyc();
      iREN     = 2'b00;
      ramstate = ACCESS;
      #1 chk("t5_drop_iwait", iwait, 2'b11);
      cyc();
      #1 chk("t5_idle", ramREN, 0);
      ramstate = FREE;

      // 5b) asynchronous reset in the middle of CPU1's REQ
      iREN         = 2'b10;
      iaddr[63:32] = 32'h800;
      ramstate     = BUSY;
      cyc();
      #1 chk("t5_grant1", grant_id, 1);
      chk("t5_ren1", ramREN, 1);
      #1 RST = 1'b1;
      #1 chk("t5_rst_ren", ramREN, 0);
      chk("t5_rst_iwait", iwait, 2'b11);
      chk("t5_rst_grant", grant_id, 0);
      chk("t5_rst_err", err_timeout, 0);
      chk("t5_rst_addr", ramaddr, 0);
      iREN     = 2'b00;
      ramstate = FREE;
      cyc();
      RST = 1'b0;
      cyc();
      cyc();
      chk("sb_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
